// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: bus bundle between the frame-buffer arbiter, its three users and the FB SRAM
// slave  : arbiter side (takes requests and FB_Q, drives grants, read returns and FB_CEN/WEN/A/D)
// master : user/SRAM side (drives requests and FB_Q, observes everything else)
// FB_ARB_STATS_EN adds the r_stall_cnt/s_stall_cnt/starve_evt_cnt observation counters.
interface fb_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 12
);
  logic [DW-1:0] bg_color;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_gnt;
  logic          r_rvalid;
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_gnt;
  logic          s_rvalid;
  logic [DW-1:0] rdata;
  logic          FB_CEN;
  logic          FB_WEN;
  logic [AW-1:0] FB_A;
  logic [DW-1:0] FB_D;
  logic [DW-1:0] FB_Q;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   r_stall_cnt;
  logic [15:0]   s_stall_cnt;
  logic [15:0]   starve_evt_cnt;
`endif
  modport slave (
    input  bg_color, clr_start, r_req, r_we, r_addr, r_wdata, s_req, s_addr, FB_Q,
    output clr_busy, clr_done, r_gnt, r_rvalid, s_gnt, s_rvalid, rdata, FB_CEN, FB_WEN, FB_A, FB_D
`ifdef FB_ARB_STATS_EN
    , output r_stall_cnt, s_stall_cnt, starve_evt_cnt
`endif
  );
  modport master (
    output bg_color, clr_start, r_req, r_we, r_addr, r_wdata, s_req, s_addr, FB_Q,
    input  clr_busy, clr_done, r_gnt, r_rvalid, s_gnt, s_rvalid, rdata, FB_CEN, FB_WEN, FB_A, FB_D
`ifdef FB_ARB_STATS_EN
    , input r_stall_cnt, s_stall_cnt, starve_evt_cnt
`endif
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: owns the single-port frame-buffer SRAM, shared by clear sequencer, render (RMW) and scan (read-only)
// Ports: clk (rising edge), rst_n (async active-low reset), bus (fb_port_arbiter_if.slave: clear control,
//        render/scan request-grant-rvalid, shared rdata, FB_CEN/FB_WEN/FB_A/FB_D/FB_Q SRAM pins).
// Optional: define FB_ARB_STATS_EN for saturating stall / starvation-event counters.
module fb_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 12,
  parameter int DEPTH      = 4096,
  parameter int STARVE_LIM = 4
) (
  input logic            clk,
  input logic            rst_n,
  fb_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          clr_done_q, r_rvalid_q, s_rvalid_q;
  logic          idle, force_r, r_gnt, s_gnt, last, clearing;
  assign clearing = state_q == CLEAR;
  // users are served only in IDLE, never in the clr_start cycle, and not while reset holds the SRAM disabled
  assign idle     = rst_n && state_q == IDLE && !bus.clr_start;
  assign force_r  = starve_q == SW'(STARVE_LIM);
  assign s_gnt    = idle && bus.s_req && !(bus.r_req && force_r);
  assign r_gnt    = idle && bus.r_req && !s_gnt;
  assign last     = cnt_q == AW'(DEPTH - 1);
  // a scan grant with r_req high is never a forced case, so it can only count up to the limit
  assign starve_d = (r_gnt || !bus.r_req) ? '0 : s_gnt ? starve_q + 1'b1 : starve_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      clr_done_q <= 1'b0;
      r_rvalid_q <= 1'b0;
      s_rvalid_q <= 1'b0;
    end else begin
      clr_done_q <= clearing && last;
      r_rvalid_q <= r_gnt && !bus.r_we;
      s_rvalid_q <= s_gnt;
      starve_q   <= starve_d;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (bus.clr_start) state_q <= CLEAR;
      end else begin
        cnt_q <= last ? cnt_q : cnt_q + 1'b1;
        if (last) state_q <= IDLE;
      end
    end
  assign bus.clr_busy = clearing;
  assign bus.clr_done = clr_done_q;
  assign bus.r_gnt    = r_gnt;
  assign bus.s_gnt    = s_gnt;
  assign bus.r_rvalid = r_rvalid_q;
  assign bus.s_rvalid = s_rvalid_q;
  assign bus.rdata    = bus.FB_Q;
  assign bus.FB_CEN   = !(clearing || r_gnt || s_gnt);
  assign bus.FB_WEN   = clearing ? 1'b0 : r_gnt ? !bus.r_we : 1'b1;
  assign bus.FB_A     = clearing ? cnt_q : r_gnt ? bus.r_addr : bus.s_addr;
  assign bus.FB_D     = clearing ? bus.bg_color : bus.r_wdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stall_q, s_stall_q, starve_evt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_stall_q    <= '0;
      s_stall_q    <= '0;
      starve_evt_q <= '0;
    end else begin
      r_stall_q    <= r_stall_q + 16'(bus.r_req && !r_gnt && r_stall_q != 16'hFFFF);
      s_stall_q    <= s_stall_q + 16'(bus.s_req && !s_gnt && s_stall_q != 16'hFFFF);
      // a render grant while scan also requests can only come from the starvation limit
      starve_evt_q <= starve_evt_q + 16'(r_gnt && bus.s_req && starve_evt_q != 16'hFFFF);
    end
  assign bus.r_stall_cnt    = r_stall_q;
  assign bus.s_stall_cnt    = s_stall_q;
  assign bus.starve_evt_cnt = starve_evt_q;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: self-checking bench with an SRAM model and a behavioural reference for fb_port_arbiter
module tb_fb_port_arbiter;
  localparam int AW = 12, DW = 12, DEPTH = 4096, LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  fb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  fb_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // write-first single-port SRAM, 1-cycle read latency
  always @(posedge clk)
    if (!bus.FB_CEN) begin
      if (!bus.FB_WEN) begin
        mem[bus.FB_A] <= bus.FB_D;
        bus.FB_Q <= bus.FB_D;
      end else bus.FB_Q <= mem[bus.FB_A];
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.clr_start = 1'b0;
    bus.r_req = 1'b0;
    bus.r_we = 1'b0;
    bus.r_addr = '0;
    bus.r_wdata = '0;
    bus.s_req = 1'b0;
    bus.s_addr = '0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    idle_inputs();
    bus.bg_color = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    bus.r_req = 1'b1;
    bus.s_req = 1'b1;
    #1;
    checks++;
    if ({bus.clr_busy, bus.clr_done, bus.r_rvalid, bus.s_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {bus.clr_busy, bus.clr_done, bus.r_rvalid, bus.s_rvalid});
    end
    checks++;
    if ({bus.FB_CEN, bus.FB_WEN} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sram_ctl got %b want 11", {bus.FB_CEN, bus.FB_WEN});
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_clear_blocking(input logic [DW-1:0] bg);
    int busy_n = 0, gnt_n = 0, c = 0;
    bus.bg_color = bg;
    bus.clr_start = 1'b1;
    bus.r_req = 1'b1;
    bus.r_we = 1'b0;
    bus.r_addr = 12'h123;
    bus.s_req = 1'b1;
    bus.s_addr = 12'h456;
    #1;
    checks++;
    if ({bus.r_gnt, bus.s_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL clr_start_cycle_gnt got %b want 00", {bus.r_gnt, bus.s_gnt});
    end
    tick();
    bus.clr_start = 1'b0;
    while (bus.clr_done !== 1'b1 && c < 5000) begin
      if (bus.clr_busy) busy_n++;
      bus.clr_start = busy_n == 2000;
      #1;
      if (bus.r_gnt || bus.s_gnt) gnt_n++;
      tick();
      c++;
    end
    bus.clr_start = 1'b0;
    checks++;
    if (bus.clr_done !== 1'b1) begin
      errors++;
      $display("FAIL clr_done_timeout got %b want 1", bus.clr_done);
    end
    checks++;
    if (busy_n != DEPTH) begin
      errors++;
      $display("FAIL clr_busy_len got %0d want %0d", busy_n, DEPTH);
    end
    checks++;
    if (gnt_n != 0) begin
      errors++;
      $display("FAIL grants_during_clear got %0d want 0", gnt_n);
    end
    #1;
    checks++;
    if ({bus.clr_busy, bus.r_gnt, bus.s_gnt} !== 3'b001) begin
      errors++;
      $display("FAIL done_cycle_busy_rgnt_sgnt got %b want 001", {bus.clr_busy, bus.r_gnt, bus.s_gnt});
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_pulse_len got %b want 0", bus.clr_done);
    end
    checks++;
    if (bus.s_rvalid !== 1'b1 || bus.rdata !== bg) begin
      errors++;
      $display("FAIL first_scan_after_clear got v=%b d=%h want v=1 d=%h", bus.s_rvalid, bus.rdata, bg);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = bg;
    tick();
  endtask
  task automatic test_scan_all();
    for (int a = 0; a <= DEPTH; a++) begin
      if (a > 0) begin
        checks++;
        if (bus.s_rvalid !== 1'b1 || bus.rdata !== ref_mem[a-1]) begin
          errors++;
          $display("FAIL scan_data[%0d] got v=%b d=%h want v=1 d=%h", a - 1, bus.s_rvalid, bus.rdata, ref_mem[a-1]);
        end
      end
      if (a < DEPTH) begin
        bus.s_req = 1'b1;
        bus.s_addr = AW'(a);
        #1;
        checks++;
        if (bus.s_gnt !== 1'b1) begin
          errors++;
          $display("FAIL scan_gnt[%0d] got %b want 1", a, bus.s_gnt);
        end
      end else bus.s_req = 1'b0;
      tick();
    end
  endtask
  task automatic test_rw();
    bus.r_req = 1'b1;
    bus.r_we = 1'b1;
    bus.r_addr = 12'h041;
    bus.r_wdata = 12'h0F0;
    #1;
    checks++;
    if ({bus.r_gnt, bus.FB_CEN, bus.FB_WEN} !== 3'b100 || bus.FB_A !== 12'h041) begin
      errors++;
      $display("FAIL rw_write_gnt got gnt/cen/wen=%b a=%h want 100 a=041", {bus.r_gnt, bus.FB_CEN, bus.FB_WEN}, bus.FB_A);
    end
    tick();
    ref_mem[12'h041] = 12'h0F0;
    checks++;
    if (bus.r_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rw_write_rvalid got %b want 0", bus.r_rvalid);
    end
    bus.r_we = 1'b0;
    #1;
    checks++;
    if (bus.r_gnt !== 1'b1 || bus.FB_WEN !== 1'b1) begin
      errors++;
      $display("FAIL rw_read_gnt got gnt=%b wen=%b want 1 1", bus.r_gnt, bus.FB_WEN);
    end
    tick();
    bus.r_req = 1'b0;
    checks++;
    if (bus.r_rvalid !== 1'b1 || bus.rdata !== 12'h0F0 || bus.s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rw_read_data got rv=%b sv=%b d=%h want 1 0 0f0", bus.r_rvalid, bus.s_rvalid, bus.rdata);
    end
    tick();
  endtask
  task automatic test_contention();
    int passed = 0, wait_cur = 0, wait_max = 0;
    logic exp_r;
    do_reset();
    bus.r_req = 1'b1;
    bus.r_we = 1'b0;
    bus.r_addr = 12'h010;
    bus.s_req = 1'b1;
    bus.s_addr = 12'h020;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_r = passed >= LIM;
      checks++;
      if ({bus.r_gnt, bus.s_gnt} !== {exp_r, !exp_r}) begin
        errors++;
        $display("FAIL contention_gnt[%0d] got rs=%b want %b", i, {bus.r_gnt, bus.s_gnt}, {exp_r, !exp_r});
      end
      passed = exp_r ? 0 : passed + 1;
      wait_cur = bus.r_gnt ? 0 : wait_cur + 1;
      if (wait_cur > wait_max) wait_max = wait_cur;
      tick();
    end
    idle_inputs();
    checks++;
    if (wait_max > LIM) begin
      errors++;
      $display("FAIL render_max_wait got %0d want <=%0d", wait_max, LIM);
    end
`ifdef FB_ARB_STATS_EN
    checks++;
    if (bus.r_stall_cnt !== 16'd10 || bus.s_stall_cnt !== 16'd2 || bus.starve_evt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats got r=%0d s=%0d e=%0d want 10 2 2", bus.r_stall_cnt, bus.s_stall_cnt, bus.starve_evt_cnt);
    end
`endif
    tick();
  endtask
  task automatic test_random(input int n);
    int passed = 0;
    logic exp_rg, exp_sg, exp_rv = 1'b0, exp_sv = 1'b0;
    logic [DW-1:0] exp_rd = '0, exp_sd = '0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.r_rvalid !== exp_rv || (exp_rv && bus.rdata !== exp_rd)) begin
        errors++;
        $display("FAIL rand_r_read[%0d] got v=%b d=%h want v=%b d=%h", i, bus.r_rvalid, bus.rdata, exp_rv, exp_rd);
      end
      checks++;
      if (bus.s_rvalid !== exp_sv || (exp_sv && bus.rdata !== exp_sd)) begin
        errors++;
        $display("FAIL rand_s_read[%0d] got v=%b d=%h want v=%b d=%h", i, bus.s_rvalid, bus.rdata, exp_sv, exp_sd);
      end
      if (!bus.r_req && $urandom_range(1, 0) == 1) begin
        bus.r_req = 1'b1;
        bus.r_we = 1'($urandom_range(1, 0));
        bus.r_addr = AW'($urandom_range(15, 0));
        bus.r_wdata = DW'($urandom);
      end
      if (!bus.s_req && $urandom_range(2, 0) != 0) begin
        bus.s_req = 1'b1;
        bus.s_addr = AW'($urandom_range(15, 0));
      end
      #1;
      exp_sg = bus.s_req && !(bus.r_req && passed >= LIM);
      exp_rg = bus.r_req && !exp_sg;
      checks++;
      if ({bus.r_gnt, bus.s_gnt} !== {exp_rg, exp_sg}) begin
        errors++;
        $display("FAIL rand_gnt[%0d] got rs=%b want %b", i, {bus.r_gnt, bus.s_gnt}, {exp_rg, exp_sg});
      end
      exp_rv = exp_rg && !bus.r_we;
      exp_rd = ref_mem[bus.r_addr];
      exp_sv = exp_sg;
      exp_sd = ref_mem[bus.s_addr];
      if (exp_rg && bus.r_we) ref_mem[bus.r_addr] = bus.r_wdata;
      passed = (bus.r_req && exp_sg) ? passed + 1 : 0;
      tick();
      if (exp_rg) bus.r_req = 1'b0;
      if (exp_sg) bus.s_req = 1'b0;
    end
    idle_inputs();
    tick();
  endtask
  task automatic test_reset_inflight();
    bus.s_req = 1'b1;
    bus.s_addr = 12'h005;
    #1;
    checks++;
    if (bus.s_gnt !== 1'b1) begin
      errors++;
      $display("FAIL inflight_s_gnt got %b want 1", bus.s_gnt);
    end
    tick();
    bus.s_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_s_rvalid_drop got %b want 0", bus.s_rvalid);
    end
    tick();
    rst_n = 1'b1;
    bus.r_req = 1'b1;
    bus.r_we = 1'b0;
    bus.r_addr = 12'h006;
    #1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.r_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_r_rvalid_drop got %b want 0", bus.r_rvalid);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset_mid_clear(input logic [DW-1:0] bg);
    int done_n = 0;
    bus.bg_color = bg;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (100) tick();
    checks++;
    if (bus.clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL midclear_busy_before got %b want 1", bus.clr_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++;
      $display("FAIL midclear_abort got busy=%b done=%b want 0 0", bus.clr_busy, bus.clr_done);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) done_n++;
    end
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL midclear_no_done got %0d want 0", done_n);
    end
    for (int i = 0; i < 100; i++) ref_mem[i] = bg;
  endtask
  initial begin
    test_reset();
    test_clear_blocking(12'b1011_1001_0111);
    test_scan_all();
    test_rw();
    test_contention();
    test_random(600);
    test_reset_inflight();
    test_reset_mid_clear(12'h5A5);
    test_scan_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
